// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers.
//   arb_lock_e : how an active grant stays locked (never, while requested,
//                or until acknowledged).
//   rr_mask    : round-robin mask to apply after granting port idx. It keeps
//                only the ports with strictly lower priority than idx. The
//                result is ARB_MAX_PORTS wide; callers truncate it to their
//                port count.
package arb_pkg;

  localparam int ARB_MAX_PORTS = 32;

  typedef enum logic [1:0] {
    ARB_LOCK_NONE,
    ARB_LOCK_REQ,
    ARB_LOCK_ACK
  } arb_lock_e;

  function automatic logic [ARB_MAX_PORTS-1:0] rr_mask(input int unsigned idx,
                                                       input logic        lsb_hi);
    logic [ARB_MAX_PORTS-1:0] one;
    logic [ARB_MAX_PORTS-1:0] below;
    one   = {{(ARB_MAX_PORTS-1){1'b0}}, 1'b1};
    below = (one << idx) - one;
    if (lsb_hi) return ~(below | (one << idx));
    else        return below;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder.
//   in_bits  : request vector
//   valid    : any bit of in_bits set
//   encoded  : index of the winning bit (0 when nothing is set)
//   one_hot  : winning bit as a one-hot vector (0 when nothing is set)
// LSB_HIGH_PRIORITY=0 makes the highest set index win; 1 makes the lowest win.
module priority_encoder #(
  parameter  int WIDTH             = 4,
  parameter  int LSB_HIGH_PRIORITY = 0,
  localparam int EW                = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic             valid,
  output logic [EW-1:0]    encoded,
  output logic [WIDTH-1:0] one_hot
);

  always_comb begin
    valid   = |in_bits;
    encoded = '0;
    // The last match in scan order wins, so the scan direction sets priority.
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_bits[i]) encoded = EW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_bits[i]) encoded = EW'(i);
      end
    end
    one_hot = valid ? (WIDTH'(1) << encoded) : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Request/grant arbiter with fixed or round-robin priority and optional locking.
//   clk           : clock; all state changes on the rising edge
//   rst           : synchronous active-high reset
//   request       : per-port level request
//   acknowledge   : per-port release pulse (only used in acknowledge-lock mode)
//   grant         : registered one-hot grant (zero when idle)
//   grant_valid   : registered, set while a grant is active
//   grant_encoded : registered index of the granted port; stale when grant_valid=0
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int PORTS             = 4,
  parameter  int ARB_ROUND_ROBIN   = 1,
  parameter  int ARB_BLOCK         = 1,
  parameter  int ARB_BLOCK_ACK     = 1,
  parameter  int LSB_HIGH_PRIORITY = 0,
  localparam int EW                = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EW-1:0]    grant_encoded
);

  localparam arb_lock_e LOCK_MODE = (ARB_BLOCK == 0)     ? ARB_LOCK_NONE :
                                    (ARB_BLOCK_ACK != 0) ? ARB_LOCK_ACK  :
                                                           ARB_LOCK_REQ;

  logic [PORTS-1:0]         mask;
  logic [PORTS-1:0]         mask_next;
  logic [ARB_MAX_PORTS-1:0] mask_full;
  logic                     locked;

  logic             m_valid, u_valid;
  logic [EW-1:0]    m_enc, u_enc;
  logic [PORTS-1:0] m_oh, u_oh;

  logic             win_valid;
  logic [EW-1:0]    win_idx;
  logic [PORTS-1:0] win_oh;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .in_bits (request & mask),
    .valid   (m_valid),
    .encoded (m_enc),
    .one_hot (m_oh)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_unmasked (
    .in_bits (request),
    .valid   (u_valid),
    .encoded (u_enc),
    .one_hot (u_oh)
  );

  // The grant is one-hot, so AND-reducing it against a port vector selects
  // the granted port's bit without indexing by grant_encoded.
  always_comb begin
    locked = 1'b0;
    case (LOCK_MODE)
      ARB_LOCK_REQ: locked = grant_valid & (|(grant & request));
      ARB_LOCK_ACK: locked = grant_valid & ~(|(grant & acknowledge));
      default:      locked = 1'b0;
    endcase
  end

  // When no masked (lower-priority) request exists, the unmasked encoder
  // supplies the wrap-around winner.
  always_comb begin
    win_valid = u_valid;
    win_idx   = u_enc;
    win_oh    = u_oh;
    if ((ARB_ROUND_ROBIN != 0) && m_valid) begin
      win_idx = m_enc;
      win_oh  = m_oh;
    end
  end

  always_comb begin
    mask_full = rr_mask(32'(win_idx), LSB_HIGH_PRIORITY != 0);
    mask_next = mask_full[PORTS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '1;
    end else if (!locked) begin
      grant         <= win_oh;
      grant_valid   <= win_valid;
      grant_encoded <= win_idx;
      // The mask advances only on a real grant, so priority does not rotate while idle.
      if (win_valid) mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter. Five arbiter configurations share one stimulus
// stream. Each has a reference model that tracks the holder and the last
// winner, and picks the next winner by walking the rotation order.
module tb_rr_arbiter;

  localparam int NC = 5;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] request;
  logic [3:0] acknowledge;

  logic [NC-1:0][3:0] gnt;
  logic [NC-1:0]      gv;
  logic [NC-1:0][1:0] genc;

  always #5 clk = ~clk;

  // cfg 0: RR, no lock | 1: RR, request lock | 2: RR, ack lock
  // cfg 3: fixed, no lock | 4: RR, request lock, LSB high priority
  rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0))
    u_dut0 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
            .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(genc[0]));
  rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0))
    u_dut1 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
            .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(genc[1]));
  rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
    u_dut2 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
            .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(genc[2]));
  rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0))
    u_dut3 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
            .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(genc[3]));
  rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1))
    u_dut4 (.clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
            .grant(gnt[4]), .grant_valid(gv[4]), .grant_encoded(genc[4]));

  function automatic bit cfg_rr(int c);
    return c != 3;
  endfunction

  // 0: no lock, 1: lock while requested, 2: lock until acknowledged
  function automatic int cfg_mode(int c);
    case (c)
      1, 4:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit cfg_lsb(int c);
    return c == 4;
  endfunction

  typedef struct packed {
    logic [NC-1:0]      v;
    logic [NC-1:0]      enc_chk;
    logic [NC-1:0][1:0] enc;
    logic [NC-1:0][3:0] g;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state per configuration; last winner -1 means nobody has won since reset.
  bit m_hv[NC];
  int m_hidx[NC];
  int m_lw[NC];

  // The port order walks away from the last winner: toward lower indices when
  // the high index has priority, toward higher indices otherwise.
  function automatic int pick(int c, logic [3:0] req);
    int start;
    int cand;
    if (req == 4'b0) return -1;
    if (!cfg_rr(c) || m_lw[c] < 0) start = cfg_lsb(c) ? -1 : 4;
    else                           start = m_lw[c];
    for (int k = 1; k <= 4; k++) begin
      cand = cfg_lsb(c) ? ((start + k + 8) % 4) : ((start - k + 8) % 4);
      if (req[cand]) return cand;
    end
    return -1;
  endfunction

  task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] ack);
    exp_t e;
    bit   lk;
    int   w;
    @(negedge clk);
    rst         = r;
    request     = req;
    acknowledge = ack;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      if (r) begin
        m_hv[c] = 0;
        m_lw[c] = -1;
        e.enc_chk[c] = 1'b1;
        e.enc[c]     = 2'd0;
      end else begin
        case (cfg_mode(c))
          1:       lk = m_hv[c] && req[m_hidx[c]];
          2:       lk = m_hv[c] && !ack[m_hidx[c]];
          default: lk = 0;
        endcase
        if (!lk) begin
          w = pick(c, req);
          if (w >= 0) begin
            m_hv[c]   = 1;
            m_hidx[c] = w;
            m_lw[c]   = w;
          end else begin
            m_hv[c] = 0;
          end
        end
        e.enc_chk[c] = m_hv[c];
        e.enc[c]     = 2'(m_hidx[c]);
      end
      e.v[c] = m_hv[c];
      e.g[c] = m_hv[c] ? (4'b0001 << m_hidx[c]) : 4'b0000;
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] req, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, req, 4'b0000);
  endtask

  // Monitor: after each rising edge, compare the DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < NC; c++) begin
          n_checks++;
          if (gnt[c] !== e.g[c]) begin
            n_errors++;
            $display("FAIL grant cfg%0d cyc%0d got=%b exp=%b", c, cyc, gnt[c], e.g[c]);
          end
          n_checks++;
          if (gv[c] !== e.v[c]) begin
            n_errors++;
            $display("FAIL grant_valid cfg%0d cyc%0d got=%b exp=%b", c, cyc, gv[c], e.v[c]);
          end
          if (e.enc_chk[c]) begin
            n_checks++;
            if (genc[c] !== e.enc[c]) begin
              n_errors++;
              $display("FAIL grant_encoded cfg%0d cyc%0d got=%0d exp=%0d", c, cyc, genc[c], e.enc[c]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] req;
    logic [3:0] ack;
    logic       r;
    rst         = 1'b1;
    request     = 4'b1111;
    acknowledge = 4'b0000;
    for (int c = 0; c < NC; c++) begin
      m_hv[c]   = 0;
      m_hidx[c] = 0;
      m_lw[c]   = -1;
    end

    // Reset held with every port requesting.
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 4'b0000);
    // Single request, then idle.
    hold(4'b0100, 1);
    hold(4'b0000, 2);
    // All ports requesting: rotation versus fixed priority.
    hold(4'b1111, 6);
    hold(4'b0000, 1);
    // Request-mode lock, then handover when the holder drops.
    drive(1'b1, 4'b0000, 4'b0000);
    hold(4'b1010, 6);
    hold(4'b0010, 3);
    // Ack-mode lock survives request drop; foreign acknowledge is ignored.
    drive(1'b1, 4'b0000, 4'b0000);
    hold(4'b0010, 2);
    hold(4'b0101, 3);
    drive(1'b0, 4'b0101, 4'b1000);
    drive(1'b0, 4'b0101, 4'b0010);
    hold(4'b0101, 2);
    // Reset in the middle of a run.
    hold(4'b1111, 3);
    drive(1'b1, 4'b1111, 4'b0100);
    hold(4'b1111, 2);

    // Random traffic; requests mostly persist so locks have time to matter.
    req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else if ($urandom_range(0, 2) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
      ack = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      r   = ($urandom_range(0, 79) == 0);
      drive(r, req, ack);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
